ch3_wave_gen: RTL and testbench

Channel 3 playback engine, directly downstream of the channel 3 register block. It consumes the decoded NR30–NR34 fields and turns them into a 4-bit DAC sample stream. It runs an 11-bit frequency timer and a 5-bit wave-position counter, fetches wave RAM bytes, and applies the volume shift. It also owns the 8-bit length counter and the channel-active flag.

---
 rtl/ch3_pkg.sv | 27 ++
 rtl/ch3_length_ctr.sv | 40 ++++
 rtl/ch3_wave_gen.sv | 106 ++++++++++
 tb/tb_ch3_wave_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch3_pkg.sv
// Shared types and constants for the channel 3 wave playback engine.
package ch3_pkg;

    localparam int FREQ_W = 11;
    localparam int POS_W  = 5;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 11'd2047;

    typedef enum logic [1:0] {
        MUTE    = 2'd0,
        FULL    = 2'd1,
        HALF    = 2'd2,
        QUARTER = 2'd3
    } vol_code_t;

    function automatic logic [3:0] vol_shift(input logic [3:0] nib, input vol_code_t code);
        logic [3:0] res;
        case (code)
            MUTE:    res = 4'd0;
            FULL:    res = nib;
            HALF:    res = nib >> 1;
            QUARTER: res = nib >> 2;
            default: res = 4'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ch3_length_ctr.sv
// 8-bit up-counting length counter; pulses expire_o when a tick wraps 255 -> 0.
module ch3_length_ctr
    import ch3_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       len_wr_i,
    input  logic [7:0] len_data_i,
    input  logic       len_tick_i,
    input  logic       len_en_i,
    input  logic       active_i,
    output logic       expire_o
);

    logic [7:0] lcnt_q;
    logic [7:0] lcnt_d;
    logic       tick_ok;

    always_comb begin
        tick_ok  = len_tick_i && len_en_i && active_i;
        lcnt_d   = lcnt_q;
        expire_o = 1'b0;
        if (len_wr_i) begin
            lcnt_d = len_data_i;
        end else if (tick_ok) begin
            // Natural 8-bit wrap; the wrap itself is what ends playback.
            lcnt_d   = lcnt_q + 8'd1;
            expire_o = (lcnt_q == 8'hFF);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lcnt_q <= 8'd0;
        end else begin
            lcnt_q <= lcnt_d;
        end
    end

endmodule

// File: rtl/ch3_wave_gen.sv
// Channel 3 playback: frequency timer, wave position, wave RAM fetch,
// volume shift and the channel-active flag.
module ch3_wave_gen #(
    parameter int FREQ_W = 11,
    parameter int POS_W  = 5
) (
    input  logic              cery_2mhz,
    input  logic              napu_reset,
    input  logic [FREQ_W-1:0] freq,
    input  logic              trigger,
    input  logic              dac_en,
    input  logic              len_en,
    input  logic              len_wr,
    input  logic [7:0]        len_data,
    input  logic              len_tick,
    input  logic [1:0]        vol,
    output logic              wave_rd,
    output logic [POS_W-2:0]  wave_addr,
    input  logic [7:0]        wave_data,
    output logic [3:0]        sample,
    output logic              active
);

    import ch3_pkg::*;

    localparam logic [FREQ_W-1:0] FTMR_TOP = {FREQ_W{1'b1}};

    logic [FREQ_W-1:0] ftmr_q, ftmr_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  pos_inc;
    logic [7:0]        wbuf_q, wbuf_d;
    logic              fetch_q, fetch_d;
    logic              active_q, active_d;
    logic              overflow;
    logic              expire;
    logic [3:0]        nib;

    ch3_length_ctr u_length_ctr (
        .clk_i      (cery_2mhz),
        .rst_ni     (napu_reset),
        .len_wr_i   (len_wr),
        .len_data_i (len_data),
        .len_tick_i (len_tick),
        .len_en_i   (len_en),
        .active_i   (active_q),
        .expire_o   (expire)
    );

    always_comb begin
        overflow  = active_q && (ftmr_q == FTMR_TOP);
        pos_inc   = pos_q + POS_W'(1);
        // A trigger overrides the overflow, so no fetch is issued that cycle.
        wave_rd   = overflow && !trigger;
        wave_addr = wave_rd ? pos_inc[POS_W-1:1] : '0;
        fetch_d   = wave_rd;

        ftmr_d = ftmr_q;
        pos_d  = pos_q;
        if (trigger) begin
            ftmr_d = freq;
            pos_d  = '0;
        end else if (overflow) begin
            ftmr_d = freq;
            pos_d  = pos_inc;
        end else if (active_q) begin
            ftmr_d = ftmr_q + FREQ_W'(1);
        end

        // Byte returns one cycle after the request; a trigger drops it.
        wbuf_d = wbuf_q;
        if (fetch_q && active_q && !trigger) begin
            wbuf_d = wave_data;
        end

        active_d = active_q;
        if (!dac_en) begin
            active_d = 1'b0;
        end else if (expire) begin
            active_d = 1'b0;
        end else if (trigger) begin
            active_d = 1'b1;
        end

        nib    = pos_q[0] ? wbuf_q[3:0] : wbuf_q[7:4];
        sample = active_q ? vol_shift(nib, vol_code_t'(vol)) : 4'd0;
    end

    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            ftmr_q   <= '0;
            pos_q    <= '0;
            wbuf_q   <= 8'd0;
            fetch_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            ftmr_q   <= ftmr_d;
            pos_q    <= pos_d;
            wbuf_q   <= wbuf_d;
            fetch_q  <= fetch_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: tb/tb_ch3_wave_gen.sv
// Bench for ch3_wave_gen: directed scenarios plus randomized traffic against
// a countdown-based reference model of the channel.
module tb_ch3_wave_gen;

    logic        cery_2mhz;
    logic        napu_reset;
    logic [10:0] freq;
    logic        trigger;
    logic        dac_en;
    logic        len_en;
    logic        len_wr;
    logic [7:0]  len_data;
    logic        len_tick;
    logic [1:0]  vol;
    logic        wave_rd;
    logic [3:0]  wave_addr;
    logic [7:0]  wave_data;
    logic [3:0]  sample;
    logic        active;

    int n_tests = 0;
    int n_fail  = 0;

    // Wave RAM behind the DUT, answers one cycle after a request.
    logic [7:0] ram [16];
    logic [3:0] rd_addr = 4'd0;

    // Reference model: clocks left until the next overflow, position,
    // held byte, outstanding fetch, length count and channel status.
    int         m_left;
    int         m_pos;
    int         m_idx;
    int         m_lcnt;
    logic [7:0] m_buf;
    bit         m_pend;
    bit         m_active;

    ch3_wave_gen dut (
        .cery_2mhz  (cery_2mhz),
        .napu_reset (napu_reset),
        .freq       (freq),
        .trigger    (trigger),
        .dac_en     (dac_en),
        .len_en     (len_en),
        .len_wr     (len_wr),
        .len_data   (len_data),
        .len_tick   (len_tick),
        .vol        (vol),
        .wave_rd    (wave_rd),
        .wave_addr  (wave_addr),
        .wave_data  (wave_data),
        .sample     (sample),
        .active     (active)
    );

    initial cery_2mhz = 1'b0;
    always #5 cery_2mhz = ~cery_2mhz;

    always @(posedge cery_2mhz) if (wave_rd) rd_addr <= wave_addr;
    assign wave_data = ram[rd_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_left   = 2048;
        m_pos    = 0;
        m_idx    = 0;
        m_lcnt   = 0;
        m_buf    = 8'd0;
        m_pend   = 0;
        m_active = 0;
    endtask

    function automatic bit exp_rd();
        return m_active && (m_left == 1) && !trigger;
    endfunction

    function automatic logic [3:0] exp_addr();
        return 4'(((m_pos + 1) % 32) / 2);
    endfunction

    function automatic logic [3:0] exp_sample();
        int nib;
        if (!m_active || vol == 2'd0) return 4'd0;
        nib = (m_pos % 2 == 1) ? int'(m_buf) % 16 : int'(m_buf) / 16;
        return 4'(nib >> (int'(vol) - 1));
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // then step the DUT to the same edge.
    task automatic advance();
        int         n_left, n_pos, n_idx, n_lcnt;
        logic [7:0] n_buf;
        bit         n_pend, n_active, ovf, expire;
        n_left = m_left; n_pos = m_pos; n_idx = m_idx; n_lcnt = m_lcnt;
        n_buf = m_buf; n_pend = 0; n_active = m_active; expire = 0;
        if (napu_reset) begin
            ovf = m_active && (m_left == 1);
            if (m_pend && m_active && !trigger) n_buf = ram[m_idx];
            if (ovf && !trigger) begin
                n_pend = 1;
                n_idx  = ((m_pos + 1) % 32) / 2;
            end
            if (trigger) begin
                n_left = 2048 - int'(freq);
                n_pos  = 0;
            end else if (ovf) begin
                n_left = 2048 - int'(freq);
                n_pos  = (m_pos + 1) % 32;
            end else if (m_active) begin
                n_left = m_left - 1;
            end
            if (len_wr) begin
                n_lcnt = int'(len_data);
            end else if (len_tick && len_en && m_active) begin
                expire = (m_lcnt == 255);
                n_lcnt = (m_lcnt + 1) % 256;
            end
            if (!dac_en) n_active = 0;
            else if (expire) n_active = 0;
            else if (trigger) n_active = 1;
        end
        @(posedge cery_2mhz);
        if (napu_reset) begin
            m_left = n_left; m_pos = n_pos; m_idx = n_idx; m_lcnt = n_lcnt;
            m_buf = n_buf; m_pend = n_pend; m_active = n_active;
        end
        #1;
    endtask

    task automatic test_reset();
        napu_reset = 1'b0;
        freq = 11'd0; trigger = 0; dac_en = 0; len_en = 0; len_wr = 0;
        len_data = 8'd0; len_tick = 0; vol = 2'd0;
        model_reset();
        #1;
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b exp 0", active); end
        n_tests++; if (sample !== 4'd0) begin n_fail++; $display("FAIL reset_sample got %0d exp 0", sample); end
        repeat (3) advance();
        napu_reset = 1'b1;
        #1;
        n_tests++; if (wave_rd !== 1'b0) begin n_fail++; $display("FAIL reset_wave_rd got %b exp 0", wave_rd); end
        n_tests++; if (wave_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wave_addr got %0d exp 0", wave_addr); end
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active_rel got %b exp 0", active); end
        advance();
    endtask

    task automatic test_basic();
        logic [7:0] b0;
        bit         want_rd;
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0] = 8'h5A;
        b0 = ram[0];
        dac_en = 1; freq = 11'd2044; vol = 2'd1;
        for (int k = 0; k < 16; k++) begin
            trigger = (k == 0);
            #1;
            want_rd = (k == 4 || k == 8 || k == 12);
            n_tests++; if (wave_rd !== want_rd) begin n_fail++; $display("FAIL basic_wave_rd k=%0d got %b exp %b", k, wave_rd, want_rd); end
            if (k == 4) begin
                n_tests++; if (wave_addr !== 4'd0) begin n_fail++; $display("FAIL basic_addr_first got %0d exp 0", wave_addr); end
            end
            if (k == 8 || k == 12) begin
                n_tests++; if (wave_addr !== 4'd1) begin n_fail++; $display("FAIL basic_addr k=%0d got %0d exp 1", k, wave_addr); end
            end
            if (k == 6) begin
                n_tests++; if (sample !== b0[3:0]) begin n_fail++; $display("FAIL basic_sample_low got %0d exp %0d", sample, b0[3:0]); end
            end
            if (k >= 1) begin
                n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL basic_active k=%0d got %b exp 1", k, active); end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [3:0] want_addr;
        freq = 11'd2047; vol = 2'd1; dac_en = 1;
        for (int k = 0; k <= 66; k++) begin
            trigger = (k == 0);
            #1;
            if (k >= 1) begin
                want_addr = 4'((k % 32) / 2);
                n_tests++; if (wave_rd !== 1'b1) begin n_fail++; $display("FAIL wrap_wave_rd k=%0d got %b exp 1", k, wave_rd); end
                n_tests++; if (wave_addr !== want_addr) begin n_fail++; $display("FAIL wrap_addr k=%0d got %0d exp %0d", k, wave_addr, want_addr); end
                n_tests++; if (sample !== exp_sample()) begin n_fail++; $display("FAIL wrap_sample k=%0d got %0d exp %0d", k, sample, exp_sample()); end
            end
            advance();
        end
    endtask

    task automatic test_volume();
        logic [3:0] tab [4];
        tab[0] = 4'd0; tab[1] = 4'd9; tab[2] = 4'd4; tab[3] = 4'd2;
        for (int i = 0; i < 16; i++) ram[i] = 8'h9C;
        dac_en = 1; vol = 2'd1;
        // Two quick reloads land on pos 2 (high nibble), then a slow reload holds it.
        for (int k = 0; k < 8; k++) begin
            trigger = (k == 0);
            freq = (k >= 3) ? 11'd0 : 11'd2046;
            #1;
            advance();
        end
        for (int v = 0; v < 4; v++) begin
            vol = 2'(v);
            #1;
            n_tests++; if (sample !== tab[v]) begin n_fail++; $display("FAIL volume_sample vol=%0d got %0d exp %0d", v, sample, tab[v]); end
            n_tests++; if (sample !== exp_sample()) begin n_fail++; $display("FAIL volume_model vol=%0d got %0d exp %0d", v, sample, exp_sample()); end
            advance();
        end
    endtask

    task automatic test_length();
        vol = 2'd1; len_en = 1;
        len_wr = 1; len_data = 8'hFE; #1; advance();
        len_wr = 0; len_tick = 1; #1; advance();
        len_tick = 0; #1;
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL length_mid_active got %b exp 1", active); end
        n_tests++; if (sample !== 4'd9) begin n_fail++; $display("FAIL length_mid_sample got %0d exp 9", sample); end
        advance();
        len_tick = 1; #1; advance();
        len_tick = 0; #1;
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL length_expire_active got %b exp 0", active); end
        n_tests++; if (sample !== 4'd0) begin n_fail++; $display("FAIL length_expire_sample got %0d exp 0", sample); end
        advance();
        // Same stimulus with the length counter disabled keeps the channel on.
        freq = 11'd0; trigger = 1; #1; advance();
        trigger = 0; len_en = 0;
        len_wr = 1; len_data = 8'hFE; #1; advance();
        len_wr = 0; len_tick = 1; #1; advance();
        len_tick = 0; #1; advance();
        len_tick = 1; #1; advance();
        len_tick = 0; #1;
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL length_disabled_active got %b exp 1", active); end
        n_tests++; if (sample !== 4'd9) begin n_fail++; $display("FAIL length_disabled_sample got %0d exp 9", sample); end
        advance();
    endtask

    task automatic test_trig_ovf();
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0] = 8'h3C; ram[1] = 8'hE5;
        dac_en = 1; vol = 2'd1; freq = 11'd2044;
        for (int k = 0; k <= 13; k++) begin
            trigger = (k == 0 || k == 8);
            #1;
            if (k == 8) begin
                n_tests++; if (m_left != 1) begin n_fail++; $display("FAIL trig_ovf_align got %0d exp 1", m_left); end
            end
            if (k >= 9 && k <= 11) begin
                n_tests++; if (wave_rd !== 1'b0) begin n_fail++; $display("FAIL trig_ovf_rd k=%0d got %b exp 0", k, wave_rd); end
            end
            if (k == 10 || k == 11) begin
                n_tests++; if (sample !== 4'd3) begin n_fail++; $display("FAIL trig_ovf_buf k=%0d got %0d exp 3", k, sample); end
            end
            if (k == 12) begin
                n_tests++; if (wave_rd !== 1'b1) begin n_fail++; $display("FAIL trig_ovf_reload got %b exp 1", wave_rd); end
                n_tests++; if (wave_addr !== 4'd0) begin n_fail++; $display("FAIL trig_ovf_addr got %0d exp 0", wave_addr); end
            end
            advance();
        end
        trigger = 0;
    endtask

    task automatic test_dac_en();
        dac_en = 0; #1; advance();
        trigger = 1; #1; advance();
        trigger = 0; #1;
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL dac_off_trigger got %b exp 0", active); end
        dac_en = 1; trigger = 1; freq = 11'd2040; #1; advance();
        trigger = 0; #1;
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL dac_on_trigger got %b exp 1", active); end
        repeat (5) advance();
        dac_en = 0; #1; advance();
        #1;
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL dac_drop_active got %b exp 0", active); end
        n_tests++; if (sample !== 4'd0) begin n_fail++; $display("FAIL dac_drop_sample got %0d exp 0", sample); end
        dac_en = 1;
    endtask

    task automatic test_reset_mid_fetch();
        ram[0] = 8'hFF;
        dac_en = 1; vol = 2'd1; freq = 11'd2047;
        trigger = 1; #1; advance();
        trigger = 0; #1;
        n_tests++; if (wave_rd !== 1'b1) begin n_fail++; $display("FAIL midfetch_rd got %b exp 1", wave_rd); end
        advance();
        napu_reset = 0;
        model_reset();
        #1;
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL midfetch_reset_active got %b exp 0", active); end
        advance(); advance();
        napu_reset = 1;
        freq = 11'd0; trigger = 1; #1; advance();
        trigger = 0;
        repeat (3) advance();
        #1;
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL midfetch_active got %b exp 1", active); end
        n_tests++; if (sample !== 4'd0) begin n_fail++; $display("FAIL midfetch_buf got %0d exp 0", sample); end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 255));
        freq = 11'd2040; len_en = 1;
        for (int c = 0; c < 1500; c++) begin
            trigger  = ($urandom_range(0, 49) == 0);
            dac_en   = ($urandom_range(0, 199) != 0);
            len_wr   = ($urandom_range(0, 99) == 0);
            len_data = 8'($urandom_range(240, 255));
            len_tick = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) len_en = ~len_en;
            if ($urandom_range(0, 49) == 0) vol = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) freq = 11'($urandom_range(2030, 2047));
            #1;
            n_tests++; if (active !== m_active) begin n_fail++; $display("FAIL rand_active c=%0d got %b exp %b", c, active, m_active); end
            n_tests++; if (sample !== exp_sample()) begin n_fail++; $display("FAIL rand_sample c=%0d got %0d exp %0d", c, sample, exp_sample()); end
            if (!trigger) begin
                n_tests++; if (wave_rd !== exp_rd()) begin n_fail++; $display("FAIL rand_wave_rd c=%0d got %b exp %b", c, wave_rd, exp_rd()); end
                if (exp_rd()) begin
                    n_tests++; if (wave_addr !== exp_addr()) begin n_fail++; $display("FAIL rand_addr c=%0d got %0d exp %0d", c, wave_addr, exp_addr()); end
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_volume();
        test_length();
        test_trig_ovf();
        test_dac_en();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
